// File: rtl/cajero_pkg.sv
// cajero_pkg: shared key codes, debounce state encoding and amount width for the ATM keypad.
package cajero_pkg;
    localparam int MONTO_W = 32;
    localparam logic [3:0] TECLA_ENTER = 4'hA;
    localparam logic [3:0] TECLA_BORRAR = 4'hB;
    typedef enum logic [1:0] {REPOSO, FILTRANDO, ESPERA_SOLTAR} estado_t;
    function automatic logic es_digito(input logic [3:0] c);
        return c <= 4'd9;
    endfunction
endpackage

// File: rtl/teclado_antirrebote.sv
// teclado_antirrebote: turns a bouncing key-down level into a single key event per press.
module teclado_antirrebote
    import cajero_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PRESIONADA,
    input  logic [3:0] CODIGO,
    output logic       EVENTO,
    output logic [3:0] CODIGO_EV
);
    localparam logic [7:0] ULTIMO = 8'(DEBOUNCE_CYCLES - 1);
    estado_t estado, estado_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] cap, cap_n;
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            estado <= REPOSO;
            cnt <= '0;
            cap <= '0;
        end else begin
            estado <= estado_n;
            cnt <= cnt_n;
            cap <= cap_n;
        end
    end
    always_comb begin
        estado_n = estado;
        cnt_n = cnt;
        cap_n = cap;
        case (estado)
            REPOSO:
                if (PRESIONADA) begin
                    estado_n = FILTRANDO;
                    cnt_n = 8'd1;
                    cap_n = CODIGO;
                end
            FILTRANDO:
                if (!PRESIONADA) begin
                    estado_n = REPOSO;
                    cnt_n = '0;
                end else if (CODIGO != cap) begin
                    cap_n = CODIGO;
                    cnt_n = 8'd1;
                end else if (cnt == ULTIMO) begin
                    estado_n = ESPERA_SOLTAR;
                    cnt_n = '0;
                end else cnt_n = cnt + 8'd1;
            ESPERA_SOLTAR:
                if (PRESIONADA) cnt_n = '0;
                else if (cnt == ULTIMO) begin
                    estado_n = REPOSO;
                    cnt_n = '0;
                end else cnt_n = cnt + 8'd1;
            default: estado_n = REPOSO;
        endcase
    end
    // Event fires on the sample that completes the stable run, so the top registers it on that same edge.
    always_comb begin
        EVENTO = estado == FILTRANDO && PRESIONADA && CODIGO == cap && cnt == ULTIMO;
        CODIGO_EV = cap;
    end
endmodule

// File: rtl/teclado_cajero.sv
// teclado_cajero: keypad front end forwarding PIN digits and accumulating decimal amounts.
// Define TECLADO_SYNC_2FF_EN to pass the raw inputs through a 2-flop synchronizer.
module teclado_cajero
    import cajero_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITOS = 9
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               TECLA_PRESIONADA,
    input  logic [3:0]         TECLA_CODIGO,
    input  logic               MODO_MONTO,
    output logic [3:0]         DIGITO,
    output logic               DIGITO_STB,
    output logic [MONTO_W-1:0] MONTO,
    output logic               MONTO_STB,
    output logic               MONTO_ERROR,
    output logic               TECLA_INVALIDA
);
    localparam int CNT_W = $clog2(MAX_DIGITOS + 1);
    logic pres_s, modo_s;
    logic [3:0] cod_s;
`ifdef TECLADO_SYNC_2FF_EN
    logic [5:0] sync1, sync2;
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {MODO_MONTO, TECLA_PRESIONADA, TECLA_CODIGO};
            sync2 <= sync1;
        end
    end
    assign {modo_s, pres_s, cod_s} = sync2;
`else
    assign {modo_s, pres_s, cod_s} = {MODO_MONTO, TECLA_PRESIONADA, TECLA_CODIGO};
`endif
    logic ev;
    logic [3:0] ev_cod;
    teclado_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
        .CLK       (CLK),
        .RESET     (RESET),
        .PRESIONADA(pres_s),
        .CODIGO    (cod_s),
        .EVENTO    (ev),
        .CODIGO_EV (ev_cod)
    );
    logic modo_prev, cambio;
    logic [MONTO_W-1:0] acc, acc_b, acc_n;
    logic [CNT_W-1:0] cnt, cnt_b, cnt_n;
    logic dig_n, mstb_n, err_n, inv_n;
    // A mode change clears the entry first; a key in the same cycle then sees the cleared state.
    always_comb begin
        cambio = modo_s != modo_prev;
        acc_b = cambio ? '0 : acc;
        cnt_b = cambio ? '0 : cnt;
        acc_n = acc_b;
        cnt_n = cnt_b;
        dig_n = 1'b0;
        mstb_n = 1'b0;
        err_n = 1'b0;
        inv_n = 1'b0;
        if (ev) begin
            if (ev_cod >= 4'hC) inv_n = 1'b1;
            else if (!modo_s) dig_n = es_digito(ev_cod);
            else if (es_digito(ev_cod)) begin
                if (cnt_b < CNT_W'(MAX_DIGITOS)) begin
                    acc_n = acc_b * MONTO_W'(10) + MONTO_W'(ev_cod);
                    cnt_n = cnt_b + CNT_W'(1);
                end else err_n = 1'b1;
            end else begin
                mstb_n = ev_cod == TECLA_ENTER && cnt_b != '0;
                err_n = ev_cod == TECLA_ENTER && cnt_b == '0;
                acc_n = '0;
                cnt_n = '0;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            modo_prev <= 1'b0;
            acc <= '0;
            cnt <= '0;
            DIGITO <= '0;
            DIGITO_STB <= 1'b0;
            MONTO <= '0;
            MONTO_STB <= 1'b0;
            MONTO_ERROR <= 1'b0;
            TECLA_INVALIDA <= 1'b0;
        end else begin
            modo_prev <= modo_s;
            acc <= acc_n;
            cnt <= cnt_n;
            DIGITO <= dig_n ? ev_cod : DIGITO;
            DIGITO_STB <= dig_n;
            MONTO <= mstb_n ? acc_b : MONTO;
            MONTO_STB <= mstb_n;
            MONTO_ERROR <= err_n;
            TECLA_INVALIDA <= inv_n;
        end
    end
endmodule
